// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the two-channel FIR MAC scheduler.
// Imported by the arbiter and the scheduler top.
package fir_sched_pkg;

  localparam int NUM_CH       = 2;
  localparam int DEF_NUM_TAPS = 16;
  localparam int DEF_TAP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant, purely combinational.
// The last-served channel is held by the parent.
module rr_arbiter_2
  import fir_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  logic              last_served,
  output logic              grant_valid,
  output logic              grant_ch
);

  // A lone request wins; on a tie the channel not served last wins.
  always_comb begin
    grant_valid = |pending;
    grant_ch    = (&pending) ? ~last_served : pending[1];
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Control sequencer sharing one FIR MAC datapath between two channels.
// Every output is a registered Moore decode of the sequencer state.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int TAP_W    = DEF_TAP_W
) (
  input  logic              Clock,
  input  logic              GlobalReset,
  input  logic [NUM_CH-1:0] srdyi,
  input  logic              clr_ovr,
  output logic              ch_sel,
  output logic [NUM_CH-1:0] shift_en,
  output logic [TAP_W-1:0]  coeff_sel,
  output logic              sum_rst,
  output logic              sum_en,
  output logic [NUM_CH-1:0] srdyo,
  output logic              busy,
  output logic [NUM_CH-1:0] overrun
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] clr_pend;
  logic              last_served;
  logic              grant_valid;
  logic              grant_ch;

  rr_arbiter_2 u_arb (
    .pending     (pending),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch)
  );

  // Pending bit consumed on the edge that starts that channel's LOAD.
  always_comb begin
    clr_pend = '0;
    if ((state == IDLE || state == DONE) && grant_valid)
      clr_pend = ch_onehot(grant_ch);
  end

  // Sample capture and sticky overrun; a new strobe beats any clear.
  always_ff @(posedge Clock) begin
    if (GlobalReset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= srdyi | (pending & ~clr_pend);
      overrun <= (srdyi & pending & ~clr_pend) |
                 (overrun & ~{NUM_CH{clr_ovr}});
    end
  end

  // Job sequencer: grant, LOAD, NUM_TAPS MAC cycles, DONE.
  always_ff @(posedge Clock) begin
    if (GlobalReset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      ch_sel      <= 1'b0;
      shift_en    <= '0;
      coeff_sel   <= '0;
      sum_rst     <= 1'b0;
      sum_en      <= 1'b0;
      srdyo       <= '0;
      busy        <= 1'b0;
    end else begin
      shift_en  <= '0;
      coeff_sel <= '0;
      sum_rst   <= 1'b0;
      sum_en    <= 1'b0;
      srdyo     <= '0;
      busy      <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (grant_valid) begin
            state       <= LOAD;
            ch_sel      <= grant_ch;
            last_served <= grant_ch;
            shift_en    <= ch_onehot(grant_ch);
            sum_rst     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          state  <= MAC;
          sum_en <= 1'b1;
        end
        MAC: begin
          if (coeff_sel == LAST_TAP) begin
            state <= DONE;
            srdyo <= ch_onehot(ch_sel);
          end else begin
            sum_en    <= 1'b1;
            coeff_sel <= coeff_sel + TAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
